// File: rtl/leaf_port_arbiter.sv
// leaf_port_arbiter: round-robin arbiter that lets NUM_REQ user requesters
// share one leaf input port. A grant lasts until the owner drops its valid
// or MAX_BURST words have been accepted. Words pass through a one-entry
// output register that drains on the leaf handshake regardless of arbiter
// state.
//
// Optional build macro LEAF_PORT_ARB_STATS_EN adds the word_cnt output:
// one wrapping 32-bit count of accepted words per requester.
module leaf_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int MAX_BURST    = 16
) (
    input  logic                            clk,
    input  logic                            ap_rst_n,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
    input  logic [NUM_REQ-1:0]              vld_req,
    output logic [NUM_REQ-1:0]              ack_req,
    output logic [PAYLOAD_BITS-1:0]         dout,
    output logic                            vld_out,
    input  logic                            ack_in,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy
`ifdef LEAF_PORT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]           word_cnt
`endif
);

    localparam int         IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_GRANT    = 1'b1;
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    // Reset release synchroniser; run goes high two edges after ap_rst_n rises
    logic [1:0]              rst_sync;
    logic                    run;

    // Arbiter state
    logic [0:0]              state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        owner;
    logic [7:0]              burst_cnt;

    // One-entry output register
    logic                    out_full;
    logic [PAYLOAD_BITS-1:0] out_data;

    // Combinational helpers
    logic [IDX_W:0]          scan_sum;
    logic [IDX_W-1:0]        scan_idx;
    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic [NUM_REQ-1:0]      pick_onehot;
    logic                    owner_vld;
    logic [PAYLOAD_BITS-1:0] owner_data;
    logic                    slot_free;
    logic                    req_xfer;
    logic                    out_xfer;
    logic                    burst_last;
    logic                    grant_exit;
    logic [IDX_W-1:0]        owner_next_ptr;

    // Two-flop synchroniser: asserts asynchronously, releases on clk
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            scan_idx = IDX_W'((scan_sum >= (IDX_W+1)'(NUM_REQ))
                              ? scan_sum - (IDX_W+1)'(NUM_REQ) : scan_sum);
            if (!pick_found && vld_req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // One-hot form of the picked requester, loaded into grant
    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_onehot[i] = pick_found && (pick_idx == IDX_W'(i));
        end
    end

    // Select valid and data of the current owner
    always_comb begin
        owner_vld  = 1'b0;
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                owner_vld  = vld_req[i];
                owner_data = din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // Output slot can take a word when empty or when it drains this cycle
    assign slot_free      = ~out_full | ack_in;
    assign req_xfer       = (state == ST_GRANT) & owner_vld & slot_free;
    assign out_xfer       = out_full & ack_in;
    assign burst_last     = req_xfer & ((burst_cnt + 8'd1) == BURST_LIMIT);
    assign grant_exit     = (state == ST_GRANT) & (~owner_vld | burst_last);
    assign owner_next_ptr = (owner == IDX_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;

    // Arbiter FSM: IDLE picks an owner, GRANT holds it until drop or burst end
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= ST_IDLE;
            grant     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (run && pick_found) begin
                state     <= ST_GRANT;
                grant     <= pick_onehot;
                owner     <= pick_idx;
                burst_cnt <= '0;
            end
        end else begin
            if (req_xfer) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
            if (grant_exit) begin
                state  <= ST_IDLE;
                grant  <= '0;
                rr_ptr <= owner_next_ptr;
            end
        end
    end

    // Output register: a simultaneous load and drain keeps it full
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_full <= 1'b0;
            out_data <= '0;
        end else if (req_xfer) begin
            out_full <= 1'b1;
            out_data <= owner_data;
        end else if (out_xfer) begin
            out_full <= 1'b0;
        end
    end

    // Only the owner is accepted, and only while the output slot is free
    always_comb begin
        ack_req = '0;
        if (state == ST_GRANT) begin
            ack_req = grant & {NUM_REQ{slot_free}};
        end
    end

    assign dout    = out_data;
    assign vld_out = out_full;
    assign busy    = (state == ST_GRANT);

`ifdef LEAF_PORT_ARB_STATS_EN
    logic [31:0] stat_cnt [NUM_REQ];

    // Per-requester wrapping count of words accepted from that requester
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
        end else if (req_xfer) begin
            stat_cnt[owner] <= stat_cnt[owner] + 32'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign word_cnt[gi*32 +: 32] = stat_cnt[gi];
    end
`endif

endmodule
